// File: rtl/gsram_pkg.sv
// Shared constants and the readout FSM state type for the GSRAM read side.
package gsram_pkg;

  localparam int unsigned GSRAM_ROWS   = 10;
  localparam int unsigned GSRAM_COLS   = 10;
  localparam int unsigned GSRAM_DATA_W = 16;
  localparam int unsigned GSRAM_ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_OUT,
    ST_DONE
  } readout_state_e;

endpackage

// File: rtl/gsram_readout_argmax_tracker.sv
// Per-row signed argmax tracker; only built when GSRAM_READOUT_ARGMAX_EN is defined.
`ifdef GSRAM_READOUT_ARGMAX_EN
module argmax_tracker
  import gsram_pkg::*;
#(
  parameter int unsigned DATA_W = GSRAM_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    sample,
  input  logic [DATA_W-1:0]       value,
  input  logic [GSRAM_ADDR_W-1:0] col,
  output logic [GSRAM_ADDR_W-1:0] idx
);

  logic signed [DATA_W-1:0]       best_q, best_d;
  logic        [GSRAM_ADDR_W-1:0] idx_q, idx_d;

  // Strictly-greater replacement keeps the lowest column on ties.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (sample && (clear || ($signed(value) > best_q))) begin
      best_d = $signed(value);
      idx_d  = col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule
`endif

// File: rtl/gsram_readout.sv
// Drains the GSRAM row-major and streams each word over valid/ready.
// Optional per-row argmax class output under GSRAM_READOUT_ARGMAX_EN.
module gsram_readout
  import gsram_pkg::*;
#(
  parameter int unsigned DATA_W = GSRAM_DATA_W,
  parameter int unsigned N_ROWS = GSRAM_ROWS,
  parameter int unsigned N_COLS = GSRAM_COLS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [GSRAM_ADDR_W-1:0] gsram_addr_row,
  output logic [GSRAM_ADDR_W-1:0] gsram_addr_col,
  output logic                    gsram_rd_en,
  input  logic [DATA_W-1:0]       gsram_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [GSRAM_ADDR_W-1:0] out_row,
  output logic [GSRAM_ADDR_W-1:0] out_col,
  output logic                    out_last,
  output logic                    class_valid,
  output logic [GSRAM_ADDR_W-1:0] class_idx,
  output logic [GSRAM_ADDR_W-1:0] class_row
);

  localparam int unsigned AW = GSRAM_ADDR_W;
  localparam logic [AW-1:0] LAST_ROW = AW'(N_ROWS - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(N_COLS - 1);

  readout_state_e    state_q, state_d;
  logic [AW-1:0]     row_q, row_d, col_q, col_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     addr_row_q, addr_row_d, addr_col_q, addr_col_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AW-1:0]     orow_q, orow_d, ocol_q, ocol_d;
  logic              is_last;

  assign is_last = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Next state, counters and capture; registered outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        data_d  = gsram_rd_data;
        orow_d  = row_q;
        ocol_d  = col_q;
        last_d  = is_last;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + AW'(1);
            end else begin
              col_d = col_q + AW'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    rd_en_d    = (state_d == ST_RD);
    addr_row_d = rd_en_d ? row_d : '0;
    addr_col_d = rd_en_d ? col_d : '0;
    valid_d    = (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_row_q <= '0;
      addr_col_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_row_q <= addr_row_d;
      addr_col_q <= addr_col_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      last_q     <= last_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign gsram_rd_en    = rd_en_q;
  assign gsram_addr_row = addr_row_q;
  assign gsram_addr_col = addr_col_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_row        = orow_q;
  assign out_col        = ocol_q;
  assign out_last       = last_q;

`ifdef GSRAM_READOUT_ARGMAX_EN
  logic          am_clear, am_sample;
  logic [AW-1:0] am_idx;

  assign am_clear  = (col_q == '0);
  assign am_sample = (state_q == ST_CAP);

  argmax_tracker #(.DATA_W(DATA_W)) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .clear  (am_clear),
    .sample (am_sample),
    .value  (gsram_rd_data),
    .col    (col_q),
    .idx    (am_idx)
  );

  // Pulses with the handshake of a row's last column; the row's argmax is already settled.
  assign class_valid = valid_q && out_ready && (ocol_q == LAST_COL);
  assign class_idx   = am_idx;
  assign class_row   = orow_q;
`else
  assign class_valid = 1'b0;
  assign class_idx   = '0;
  assign class_row   = '0;
`endif

endmodule

// File: tb/tb_gsram_readout.sv
// Directed bench for gsram_readout: full drains, backpressure, argmax rows, mid-drain reset.
module tb_gsram_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, gsram_rd_en, out_valid, out_last, class_valid;
  logic [3:0]  gsram_addr_row, gsram_addr_col, out_row, out_col, class_idx, class_row;
  logic [15:0] gsram_rd_data = 16'd0;
  logic [15:0] out_data;

  logic [15:0] mem [10][10];
  logic [3:0]  exp_cls [10];
  int          total = 0;
  int          bad = 0;

  gsram_readout dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .gsram_addr_row (gsram_addr_row),
    .gsram_addr_col (gsram_addr_col),
    .gsram_rd_en    (gsram_rd_en),
    .gsram_rd_data  (gsram_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .class_valid    (class_valid),
    .class_idx      (class_idx),
    .class_row      (class_row)
  );

  always #5 clk = ~clk;

  // GSRAM model: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (gsram_rd_en) begin
      if (gsram_addr_row < 4'd10 && gsram_addr_col < 4'd10)
        gsram_rd_data <= mem[gsram_addr_row][gsram_addr_col];
      else
        gsram_rd_data <= 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_busy"},        16'(busy),           16'd0);
    chk({tag, "_done"},        16'(done),           16'd0);
    chk({tag, "_rd_en"},       16'(gsram_rd_en),    16'd0);
    chk({tag, "_addr_row"},    16'(gsram_addr_row), 16'd0);
    chk({tag, "_addr_col"},    16'(gsram_addr_col), 16'd0);
    chk({tag, "_out_valid"},   16'(out_valid),      16'd0);
    chk({tag, "_out_data"},    out_data,            16'd0);
    chk({tag, "_out_row"},     16'(out_row),        16'd0);
    chk({tag, "_out_col"},     16'(out_col),        16'd0);
    chk({tag, "_out_last"},    16'(out_last),       16'd0);
    chk({tag, "_class_valid"}, 16'(class_valid),    16'd0);
    chk({tag, "_class_idx"},   16'(class_idx),      16'd0);
    chk({tag, "_class_row"},   16'(class_row),      16'd0);
  endtask

  // One drain from a start pulse; the expected RD/CAP/OUT/DONE timeline is tracked independently.
  task automatic drain(input bit bp, input int start_at, input int abort_word, input bit start_in_done);
    bit exp_rd, exp_cap, exp_valid, exp_done, prev_stall, cv, hs;
    int words, obs_words, first_obs, done_obs, model_done, r, c;
    logic [15:0] held;
    exp_rd = 1'b1; exp_cap = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
    prev_stall = 1'b0; held = 16'd0;
    words = 0; obs_words = 0; first_obs = -1; done_obs = -1; model_done = -1;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 3000 && model_done < 0; cyc++) begin
      out_ready = bp ? (((cyc * 13) % 11) < 5) : 1'b1;
      start = (cyc == start_at) || (exp_done && start_in_done);
      #1;
      r = words / 10;
      c = words % 10;
      if (out_valid && first_obs < 0) first_obs = cyc;
      if (done && done_obs < 0) done_obs = cyc;
      if (out_valid && out_ready) obs_words++;
      chk("busy", 16'(busy), 16'd1);
      chk("done", 16'(done), 16'(exp_done));
      chk("rd_en", 16'(gsram_rd_en), 16'(exp_rd));
      chk("addr_row", 16'(gsram_addr_row), exp_rd ? 16'(r) : 16'd0);
      chk("addr_col", 16'(gsram_addr_col), exp_rd ? 16'(c) : 16'd0);
      chk("out_valid", 16'(out_valid), 16'(exp_valid));
      if (exp_valid) begin
        if (prev_stall) chk("stall_hold", out_data, held);
        chk("out_data", out_data, mem[r][c]);
        chk("out_row", 16'(out_row), 16'(r));
        chk("out_col", 16'(out_col), 16'(c));
        chk("out_last", 16'(out_last), 16'(words == 99));
        if (words == abort_word) begin
          reset = 1'b1;
          start = 1'b0;
          step();
          zeros("abort");
          reset = 1'b0;
          return;
        end
      end
      hs = exp_valid && out_ready;
      cv = 1'b0;
`ifdef GSRAM_READOUT_ARGMAX_EN
      cv = hs && (c == 9);
      if (cv) begin
        chk("class_idx", 16'(class_idx), 16'(exp_cls[r]));
        chk("class_row", 16'(class_row), 16'(r));
      end
`else
      chk("class_idx", 16'(class_idx), 16'd0);
      chk("class_row", 16'(class_row), 16'd0);
`endif
      chk("class_valid", 16'(class_valid), 16'(cv));
      if (exp_done) model_done = cyc;
      prev_stall = exp_valid && !out_ready;
      held = out_data;
      exp_done  = hs && (words == 99);
      exp_valid = exp_cap || (exp_valid && !out_ready);
      exp_cap   = exp_rd;
      exp_rd    = hs && (words != 99);
      if (hs) words++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("drain_ended", 16'(model_done > 0), 16'd1);
    chk("word_count", 16'(obs_words), 16'd100);
    chk("first_valid", 16'(first_obs), 16'd3);
    chk("done_cycle", 16'(done_obs), 16'(model_done));
    if (!bp) chk("done_301", 16'(done_obs), 16'd301);
    #1;
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_rd_en", 16'(gsram_rd_en), 16'd0);
    step();
    chk("idle2_busy", 16'(busy), 16'd0);
    chk("idle2_rd_en", 16'(gsram_rd_en), 16'd0);
  endtask

  initial begin
    for (int r = 0; r < 10; r++) begin
      exp_cls[r] = 4'd9;
      for (int c = 0; c < 10; c++) mem[r][c] = 16'(r * 10 + c);
    end

    reset = 1'b1;
    step();
    step();
    zeros("reset");
    reset = 1'b0;
    step();
    chk("post_reset_busy", 16'(busy), 16'd0);

    // Ascending fill, full-rate ready, start pulsed in the DONE cycle.
    drain(1'b0, -1, -1, 1'b1);

    // Argmax rows: tie picks lower column; all-negative row picks least negative.
    mem[3][0] = 16'(-5); mem[3][1] = 16'd7;  mem[3][2] = 16'd7;  mem[3][3] = 16'd2;
    mem[3][4] = 16'(-1); mem[3][5] = 16'd0;  mem[3][6] = 16'd0;  mem[3][7] = 16'd0;
    mem[3][8] = 16'd0;   mem[3][9] = 16'd0;
    mem[5][0] = 16'(-9); mem[5][1] = 16'(-7); mem[5][2] = 16'(-3); mem[5][3] = 16'(-8);
    mem[5][4] = 16'(-3); mem[5][5] = 16'(-50); mem[5][6] = 16'(-4); mem[5][7] = 16'(-5);
    mem[5][8] = 16'(-6); mem[5][9] = 16'(-8);
    exp_cls[3] = 4'd1;
    exp_cls[5] = 4'd2;

    // Backpressure with a spurious start mid-drain.
    drain(1'b1, 50, -1, 1'b0);

    // Reset at word 42, then a fresh drain from (0,0).
    drain(1'b0, -1, 42, 1'b0);
    step();
    drain(1'b0, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
